pool_window_gen: RTL and testbench
==================================

# pool_window_gen

Streaming window generator that feeds the 2x2 max-pooling stage. It accepts a raster-order pixel stream from the convolution output, one pixel per accepted cycle, and buffers one even image row. On each odd-row/odd-column pixel it emits the four pixels of the non-overlapping 2x2 window in parallel, so the combinational max comparator downstream sees a complete window with a one-cycle valid strobe.

## Interface
- DATA_W, 16, pixel width in bits
- IMG_W, 64, image width in pixels; even, at least 2
- IMG_H, 64, image height in pixels; even, at least 2

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  in_data is a valid pixel this cycle; no backpressure, gaps allowed
- in_data  input  DATA_W  pixel, raster order (row 0 col 0 first), unsigned
- win_valid  output  1  one-cycle strobe: win_d1..win_d4, win_row, win_col valid
- win_d1  output  DATA_W  top-left pixel (even row, even col)
- win_d2  output  DATA_W  top-right pixel (even row, odd col)
- win_d3  output  DATA_W  bottom-left pixel (odd row, even col)
- win_d4  output  DATA_W  bottom-right pixel (odd row, odd col)
- win_row  output  clog2(IMG_H/2)  pooled-output row index, 0..IMG_H/2-1
- win_col  output  clog2(IMG_W/2)  pooled-output column index, 0..IMG_W/2-1
- frame_done  output  1  one-cycle strobe, coincident with the final window of a frame

## Operation
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid. col wraps to 0 at IMG_W-1 and increments row. row wraps to 0 after IMG_H-1; the next pixel starts a new frame with no idle cycle required.
- Even row: each pixel is written to line_buf[col]. No output.
- Odd row, even col:
  - Latch in_data as bottom-left.
  - Latch line_buf[col] as top-left.
- Odd row, odd col, on the next clock edge:
  - win_d1 = latched top-left; win_d2 = line_buf[col]; win_d3 = latched bottom-left; win_d4 = in_data.
  - win_row = row>>1; win_col = col>>1; win_valid = 1.
- frame_done = 1 together with win_valid when the accepted pixel was row IMG_H-1, col IMG_W-1.
- Data is passed through unmodified; no arithmetic on pixel values.
- Reset mid-frame: counters go to 0 and the next in_valid pixel is row 0 col 0. Line buffer contents need not be cleared, because every location is rewritten before it is read.
- Reset values:
  - win_valid, frame_done: 0
  - win_d1..win_d4, win_row, win_col: 0
  - col, row, bottom-left and top-left latches: 0

## Timing
- Latency: win_valid asserts exactly 1 cycle after the cycle in which the bottom-right pixel was accepted (in_valid high).
- win_valid and frame_done are high for a single cycle per window and are never held.
- Window outputs hold their last values until the next window. The downstream stage samples only on win_valid.
- Maximum window throughput is 1 per 2 accepted pixels on odd rows. Minimum spacing between win_valid strobes is 2 cycles.
- in_valid gaps of any length are allowed at any position, including between the even-col and odd-col pixels of a window. The latches hold across gaps.
- The line buffer has one read or one write per cycle:
  - write on even rows;
  - read on odd rows, at both even and odd columns.

## Structure
- Shared package holds:
  - DATA_W default;
  - image-dimension defaults;
  - derived widths clog2(IMG_W), clog2(IMG_H), clog2(IMG_W/2), clog2(IMG_H/2);
  - window-position naming constants (TL/TR/BL/BR).
- Sub-module `pool_line_buf`: IMG_W x DATA_W single-port storage with synchronous write and combinational read; replaceable by an SRAM macro. Everything else (counters, latches, output registers) sits in pool_window_gen.

## Test plan
- 4x4 frame, pixels 0..15 contiguous:
  - windows (1,2,3,4) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15);
  - win_valid 1 cycle after pixels 5, 7, 13, 15;
  - (win_row, win_col) = (0,0), (0,1), (1,0), (1,1);
  - frame_done only with the last window.
- Same frame with random 0-3 cycle in_valid gaps, including between pixels 12 and 13 -> identical window values and ordering; each strobe 1 cycle after its pixel 5/7/13/15.
- Two back-to-back 4x4 frames (values 0..15, then 100..115) with no gap -> second frame's windows start with (100,101,104,105); frame_done exactly twice.
- Reset asserted after pixel 9, then a full frame 200..215 -> no window from the aborted frame; first window is (200,201,204,205); all outputs 0 during reset.
- Extremes on IMG_W=64, IMG_H=2 (row 0 all 0xFFFF, row 1 all 0x0000) -> 32 windows of (FFFF,FFFF,0000,0000); win_col 0..31; frame_done on window 31.

Source files
------------

// File: rtl/pool_window_gen_pkg.sv
// Shared defaults and helpers for the 2x2 pooling window generator.
package pool_window_gen_pkg;

    // Width helper that never collapses to a zero-width vector.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DATA_W_DEF = 16;
    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;

    localparam int COL_W_DEF  = cw(IMG_W_DEF);
    localparam int ROW_W_DEF  = cw(IMG_H_DEF);
    localparam int WCOL_W_DEF = cw(IMG_W_DEF / 2);
    localparam int WROW_W_DEF = cw(IMG_H_DEF / 2);

    typedef enum logic [1:0] {
        POS_TL = 2'd0,
        POS_TR = 2'd1,
        POS_BL = 2'd2,
        POS_BR = 2'd3
    } win_pos_e;

endpackage

// File: rtl/pool_line_buf.sv
// Single-port row storage: synchronous write, combinational read.
// Kept separate so it can be swapped for an SRAM macro.
module pool_line_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 window generator: buffers one even row and emits
// a full non-overlapping window on each odd-row/odd-column pixel.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      win_valid,
    output logic [DATA_W-1:0]         win_d1,
    output logic [DATA_W-1:0]         win_d2,
    output logic [DATA_W-1:0]         win_d3,
    output logic [DATA_W-1:0]         win_d4,
    output logic [cw(IMG_H/2)-1:0]    win_row,
    output logic [cw(IMG_W/2)-1:0]    win_col,
    output logic                      frame_done
);

    localparam int CW  = cw(IMG_W);
    localparam int RW  = cw(IMG_H);
    localparam int WCW = cw(IMG_W / 2);
    localparam int WRW = cw(IMG_H / 2);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] tl;
    logic [DATA_W-1:0] bl;
    logic [DATA_W-1:0] rd_data;
    logic              last_col;
    logic              last_row;
    logic              odd_row;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign odd_row  = row[0];

    // Even rows fill the buffer; odd rows only read it.
    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (in_valid && !odd_row),
        .addr  (col),
        .wdata (in_data),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            tl         <= '0;
            bl         <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_d1     <= '0;
            win_d2     <= '0;
            win_d3     <= '0;
            win_d4     <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                col <= last_col ? '0 : col + CW'(1);
                if (last_col) begin
                    row <= last_row ? '0 : row + RW'(1);
                end
                unique case (1'b1)
                    odd_row && !col[0]: begin
                        tl <= rd_data;
                        bl <= in_data;
                    end
                    odd_row && col[0]: begin
                        win_d1     <= tl;
                        win_d2     <= rd_data;
                        win_d3     <= bl;
                        win_d4     <= in_data;
                        win_row    <= WRW'(row >> 1);
                        win_col    <= WCW'(col >> 1);
                        win_valid  <= 1'b1;
                        frame_done <= last_row && last_col;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench: a 4x4 instance for frame/gap/reset cases and
// a 64x2 instance for the wide-row extremes.
module tb_pool_window_gen;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4x4 instance
    logic          iv;
    logic [DW-1:0] id;
    logic          wv;
    logic [DW-1:0] d1, d2, d3, d4;
    logic [0:0]    wr;
    logic [0:0]    wc;
    logic          fd;

    // 64x2 instance
    logic          xiv;
    logic [DW-1:0] xid;
    logic          xwv;
    logic [DW-1:0] x1, x2, x3, x4;
    logic [0:0]    xwr;
    logic [4:0]    xwc;
    logic          xfd;

    pool_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(iv), .in_data(id),
        .win_valid(wv), .win_d1(d1), .win_d2(d2), .win_d3(d3),
        .win_d4(d4), .win_row(wr), .win_col(wc), .frame_done(fd)
    );

    pool_window_gen #(.DATA_W(DW), .IMG_W(64), .IMG_H(2)) u_wide (
        .clk(clk), .reset(reset), .in_valid(xiv), .in_data(xid),
        .win_valid(xwv), .win_d1(x1), .win_d2(x2), .win_d3(x3),
        .win_d4(x4), .win_row(xwr), .win_col(xwc), .frame_done(xfd)
    );

    typedef struct {
        logic [63:0] win;
        int          r;
        int          c;
        bit          fd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t xq[$];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    int xfd_cnt = 0;

    logic [DW-1:0] pix [4][4];
    int mr, mc;
    int xc;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one 4x4 pixel after 'gap' idle cycles; model the window.
    task automatic send(input logic [DW-1:0] d, input int gap);
        exp_t e;
        if (gap > 0) begin
            iv = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        iv = 1'b1;
        id = d;
        pix[mr][mc] = d;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            e.win = {pix[mr-1][mc-1], pix[mr-1][mc], pix[mr][mc-1], d};
            e.r   = mr / 2;
            e.c   = mc / 2;
            e.fd  = (mr == 3) && (mc == 3);
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        mc++;
        if (mc == 4) begin
            mc = 0;
            mr = (mr + 1) % 4;
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d);
        exp_t e;
        xiv = 1'b1;
        xid = d;
        if (xc >= 64 && (xc % 2 == 1)) begin
            e.win = {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
            e.r   = 0;
            e.c   = (xc - 64) / 2;
            e.fd  = (xc == 127);
            e.cyc = cyc + 1;
            xq.push_back(e);
        end
        xc++;
        @(posedge clk);
        #1;
        xiv = 1'b0;
    endtask

    task automatic frame(input int base, input int rnd_gap);
        for (int i = 0; i < 16; i++) begin
            int g;
            g = rnd_gap ? $urandom_range(0, 3) : 0;
            if (rnd_gap && i == 13 && g == 0) g = 2;
            send(DW'(base + i), g);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fd && !wv) check("fd_stray", 1, 0);
        if (fd) fd_cnt++;
        if (wv) begin
            if (q.size() == 0) begin
                check("unexpected_win", 1, 0);
            end else begin
                e = q.pop_front();
                check("win", {d1, d2, d3, d4}, e.win);
                check("row", 64'(wr), 64'(e.r));
                check("col", 64'(wc), 64'(e.c));
                check("fd", 64'(fd), 64'(e.fd));
                check("lat", 64'(cyc), 64'(e.cyc));
            end
        end
        if (xfd && !xwv) check("xfd_stray", 1, 0);
        if (xfd) xfd_cnt++;
        if (xwv) begin
            if (xq.size() == 0) begin
                check("x_unexpected_win", 1, 0);
            end else begin
                e = xq.pop_front();
                check("x_win", {x1, x2, x3, x4}, e.win);
                check("x_row", 64'(xwr), 64'(e.r));
                check("x_col", 64'(xwc), 64'(e.c));
                check("x_fd", 64'(xfd), 64'(e.fd));
                check("x_lat", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        reset = 1'b1;
        iv = 1'b0;
        id = '0;
        xiv = 1'b0;
        xid = '0;
        mr = 0;
        mc = 0;
        xc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", {wv, fd, d1, d2, d3, d4, wr, wc}, 0);
        check("rst_xout", {xwv, xfd, x1, x2, x3, x4, xwr, xwc}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        frame(0, 0);
        repeat (3) begin @(posedge clk); #1; end
        frame(0, 1);
        repeat (3) begin @(posedge clk); #1; end
        frame(0, 0);
        frame(100, 0);
        repeat (3) begin @(posedge clk); #1; end

        for (int i = 0; i < 10; i++) send(DW'(50 + i), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", {wv, fd, d1, d2, d3, d4, wr, wc}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mr = 0;
        mc = 0;
        check("mid_rst_q", 64'(q.size()), 0);
        frame(200, 0);
        repeat (3) begin @(posedge clk); #1; end

        for (int i = 0; i < 64; i++) send_w(16'hFFFF);
        for (int i = 0; i < 64; i++) send_w(16'h0000);
        repeat (4) begin @(posedge clk); #1; end

        check("pending", 64'(q.size()), 0);
        check("x_pending", 64'(xq.size()), 0);
        check("fd_total", 64'(fd_cnt), 5);
        check("xfd_total", 64'(xfd_cnt), 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
